layer_mac: RTL and testbench

Sequential multiply-accumulate engine for one fully-connected layer. It sits directly upstream of the activation/sigmoid stage in the forward-propagation datapath. It buffers an input feature vector, then for each neuron in turn computes bias + Σ(weight·input) from an external synchronous weight/bias ROM. Each neuron's 64-bit pre-activation sum is handed downstream over a valid/ready handshake.

---
 rtl/layer_mac.sv | 150 +++++++++++++++
 tb/tb_layer_mac.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_mac.sv
// Sequential multiply-accumulate for one fully-connected layer: buffers a feature
// vector, then streams bias + sum(weight*input) per neuron over valid/ready.
module layer_mac #(
  parameter int N_IN     = 15,
  parameter int N_NEURON = 10,
  parameter int AW       = 8,
  parameter int BW       = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   x_in,
  output logic [AW-1:0] w_addr,
  input  logic [31:0]   w_data,
  output logic [BW-1:0] b_addr,
  input  logic [31:0]   b_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [63:0]   out_data,
  output logic [3:0]    out_idx,
  output logic          busy,
  output logic          done
);

  localparam int DATA_W = 32;
  localparam int COEF_W = 32;
  localparam int ACC_W  = 64;
  localparam int SUM_W  = ACC_W + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_MAC, S_DRAIN, S_OUT, S_DONE
  } state_t;

  state_t state, state_nx;

  logic [AW-1:0]             cnt;
  logic [AW-1:0]             k;
  logic [BW-1:0]             neuron;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   acc_nx;
  logic signed [DATA_W-1:0]  xbuf [N_IN];

  logic signed [COEF_W-1:0]  w_s;
  logic signed [COEF_W-1:0]  b_s;
  logic signed [ACC_W-1:0]   prod;
  logic signed [COEF_W+15:0] bias_sh;
  logic signed [SUM_W-1:0]   sum;
  logic                      add_prod;
  logic                      add_bias;
  logic                      last_k;
  logic                      last_cnt;
  logic                      last_neuron;

  // Clamp a widened sum back into the 64-bit signed accumulator range.
  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [SUM_W-1:0] s);
    if (s[SUM_W-1:ACC_W-1] == '0 || s[SUM_W-1:ACC_W-1] == '1)
      return s[ACC_W-1:0];
    else if (s[SUM_W-1])
      return {1'b1, {(ACC_W-1){1'b0}}};
    else
      return {1'b0, {(ACC_W-1){1'b1}}};
  endfunction

  assign last_k      = (k == AW'(N_IN - 1));
  assign last_cnt    = (cnt == AW'(N_IN - 1));
  assign last_neuron = (neuron == BW'(N_NEURON - 1));

  // ROM data arrives one cycle after its address, so MAC cycle k consumes term k-1.
  assign add_prod = (state == S_MAC && k != '0) || state == S_DRAIN;
  assign add_bias = (state == S_MAC && k == AW'(1)) || (state == S_DRAIN && N_IN == 1);

  assign w_s     = w_data;
  assign b_s     = b_data;
  assign prod    = ACC_W'(w_s) * ACC_W'(xbuf[0]);
  assign bias_sh = {b_s, 16'h0000};
  assign sum     = SUM_W'(acc)
                 + (add_prod ? SUM_W'(prod) : '0)
                 + (add_bias ? SUM_W'(bias_sh) : '0);
  assign acc_nx  = sat_acc(sum);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_LOAD;
      S_LOAD:  if (in_valid && last_cnt) state_nx = S_MAC;
      S_MAC:   if (last_k) state_nx = S_DRAIN;
      S_DRAIN: state_nx = S_OUT;
      S_OUT:   if (out_ready) state_nx = last_neuron ? S_DONE : S_MAC;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      k      <= '0;
      neuron <= '0;
      acc    <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: if (start) cnt <= '0;
        S_LOAD: if (in_valid) begin
          cnt <= last_cnt ? '0 : cnt + 1'b1;
          if (last_cnt) begin
            k      <= '0;
            neuron <= '0;
          end
        end
        S_MAC: begin
          acc <= (k == '0) ? '0 : acc_nx;
          k   <= k + 1'b1;
        end
        S_DRAIN: acc <= acc_nx;
        S_OUT: if (out_ready) begin
          k <= '0;
          if (!last_neuron) neuron <= neuron + 1'b1;
        end
        S_DONE: neuron <= '0;
        default: ;
      endcase
    end
  end

  // Samples shift in at the top; each consumed term rotates the ring so that
  // after N_IN products the buffer is back in load order for the next neuron.
  always_ff @(posedge clk) begin
    if (state == S_LOAD && in_valid) begin
      for (int i = 0; i < N_IN - 1; i++) xbuf[i] <= xbuf[i+1];
      xbuf[N_IN-1] <= x_in;
    end else if (add_prod) begin
      for (int i = 0; i < N_IN - 1; i++) xbuf[i] <= xbuf[i+1];
      xbuf[N_IN-1] <= xbuf[0];
    end
  end

  assign in_ready  = (state == S_LOAD);
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_OUT);
  assign done      = (state == S_DONE);
  assign out_data  = acc;
  assign out_idx   = 4'(neuron);
  assign w_addr    = (state == S_MAC) ? AW'(neuron) * AW'(N_IN) + k : '0;
  assign b_addr    = (state == S_MAC) ? neuron : '0;

endmodule

// File: tb/tb_layer_mac.sv
// Directed bench for layer_mac with N_IN=3, N_NEURON=2 and a 1-cycle ROM model.
module tb_layer_mac;

  localparam int N_IN = 3;
  localparam int N_NEURON = 2;
  localparam int AW = 8;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rst_n, start, in_valid, in_ready, out_valid, out_ready, busy, done;
  logic [31:0]   x_in, w_data, b_data;
  logic [AW-1:0] w_addr;
  logic [BW-1:0] b_addr;
  logic [63:0]   out_data;
  logic [3:0]    out_idx;

  always #5 clk = ~clk;

  layer_mac #(.N_IN(N_IN), .N_NEURON(N_NEURON), .AW(AW), .BW(BW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .w_addr(w_addr), .w_data(w_data), .b_addr(b_addr), .b_data(b_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .busy(busy), .done(done)
  );

  logic [31:0] wrom [256];
  logic [31:0] brom [16];

  always @(posedge clk) begin
    w_data <= wrom[w_addr];
    b_data <= brom[b_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] res_d [$];
  logic [3:0]  res_i [$];
  int          res_c [$];
  int          done_cnt = 0;
  int          done_cyc = 0;

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      res_d.push_back(out_data);
      res_i.push_back(out_idx);
      res_c.push_back(cyc);
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string p);
    check({p, "_in_ready"},  64'(in_ready),  64'd0);
    check({p, "_out_valid"}, 64'(out_valid), 64'd0);
    check({p, "_out_data"},  out_data,       64'd0);
    check({p, "_out_idx"},   64'(out_idx),   64'd0);
    check({p, "_w_addr"},    64'(w_addr),    64'd0);
    check({p, "_b_addr"},    64'(b_addr),    64'd0);
    check({p, "_busy"},      64'(busy),      64'd0);
    check({p, "_done"},      64'(done),      64'd0);
  endtask

  task automatic set_basic_rom();
    wrom[0] = 32'h0000_8000; wrom[1] = 32'h0000_8000; wrom[2] = 32'h0000_8000;
    wrom[3] = 32'h0001_0000; wrom[4] = 32'hFFFF_0000; wrom[5] = 32'h0002_0000;
    brom[0] = 32'h0000_0000; brom[1] = 32'h0000_4000;
  endtask

  task automatic pulse_start(output int sc);
    start = 1'b1;
    tick();
    start = 1'b0;
    sc = cyc;
  endtask

  task automatic feed(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                      input logic [7:0] pat, input int glitch);
    logic [31:0] xs [3];
    int idx;
    int i;
    xs = '{a, b, c};
    idx = 0;
    i = 0;
    while (idx < 3 && i < 8) begin
      in_valid = pat[i];
      x_in = pat[i] ? xs[idx] : 32'hDEAD_BEEF;
      start = (i == glitch);
      tick();
      if (pat[i]) idx++;
      i++;
    end
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_res(input int target, input int budget);
    int n;
    n = 0;
    while (res_d.size() < target && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!out_valid && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic check_pair(input string p, input int base, input int dbase,
                            input logic [63:0] e0, input logic [63:0] e1);
    check({p, "_count"}, 64'(res_d.size() - base), 64'd2);
    check({p, "_data0"}, res_d[base], e0);
    check({p, "_idx0"},  64'(res_i[base]), 64'd0);
    check({p, "_data1"}, res_d[base+1], e1);
    check({p, "_idx1"},  64'(res_i[base+1]), 64'd1);
    check({p, "_done"},  64'(done_cnt - dbase), 64'd1);
  endtask

  localparam logic [31:0] X0 = 32'h0001_0000;
  localparam logic [31:0] X1 = 32'h0002_0000;
  localparam logic [31:0] X2 = 32'h0003_0000;
  localparam logic [63:0] R0 = 64'h0000_0003_0000_0000;
  localparam logic [63:0] R1 = 64'h0000_0005_4000_0000;

  initial begin
    int base, db, sc;
    logic [63:0] hold_d;
    logic [AW-1:0] hold_w;
    int n;

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; x_in = '0; out_ready = 1'b1;
    for (int a = 0; a < 256; a++) wrom[a] = '0;
    for (int a = 0; a < 16; a++) brom[a] = '0;
    repeat (3) tick();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick();
    set_basic_rom();

    // basic pass with latency checks
    base = res_d.size(); db = done_cnt;
    pulse_start(sc);
    check("start_busy", 64'(busy), 64'd1);
    check("start_in_ready", 64'(in_ready), 64'd1);
    feed(X0, X1, X2, 8'hFF, -1);
    wait_res(base + 2, 60);
    repeat (3) tick();
    check_pair("basic", base, db, R0, R1);
    check("lat_first_out", 64'(res_c[base] - sc), 64'd7);
    check("lat_done", 64'(done_cyc - sc), 64'd13);
    check("basic_idle", 64'(busy), 64'd0);

    // back-pressure on neuron 0
    out_ready = 1'b0;
    base = res_d.size(); db = done_cnt;
    pulse_start(sc);
    feed(X0, X1, X2, 8'hFF, -1);
    wait_valid(40);
    check("bp_valid_rise", 64'(out_valid), 64'd1);
    hold_d = out_data;
    hold_w = w_addr;
    repeat (5) tick();
    check("bp_valid_hold", 64'(out_valid), 64'd1);
    check("bp_data_hold", out_data, hold_d);
    check("bp_idx_hold", 64'(out_idx), 64'd0);
    check("bp_waddr_hold", 64'(w_addr), 64'(hold_w));
    check("bp_data_value", hold_d, R0);
    out_ready = 1'b1;
    wait_res(base + 2, 60);
    repeat (3) tick();
    check_pair("bp", base, db, R0, R1);

    // input stalls 1,0,0,1,0,1
    base = res_d.size(); db = done_cnt;
    pulse_start(sc);
    feed(X0, X1, X2, 8'b0010_1001, -1);
    wait_res(base + 2, 60);
    repeat (3) tick();
    check_pair("stall", base, db, R0, R1);

    // saturation both directions
    for (int a = 0; a < 3; a++) wrom[a] = 32'h7FFF_FFFF;
    for (int a = 3; a < 6; a++) wrom[a] = 32'h8000_0000;
    brom[0] = 32'h7FFF_FFFF; brom[1] = 32'h0000_0000;
    base = res_d.size(); db = done_cnt;
    pulse_start(sc);
    feed(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 8'hFF, -1);
    wait_res(base + 2, 60);
    repeat (3) tick();
    check_pair("sat", base, db, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000);

    // reset during neuron 1 MAC
    set_basic_rom();
    base = res_d.size(); db = done_cnt;
    pulse_start(sc);
    feed(X0, X1, X2, 8'hFF, -1);
    n = 0;
    while (w_addr != 8'd4 && n < 40) begin
      tick();
      n++;
    end
    check("midrst_reached", 64'(w_addr), 64'd4);
    rst_n = 1'b0;
    tick();
    check_idle_outputs("midrst");
    rst_n = 1'b1;
    repeat (4) tick();
    check("midrst_no_done", 64'(done_cnt - db), 64'd0);
    check("midrst_results", 64'(res_d.size() - base), 64'd1);
    base = res_d.size(); db = done_cnt;
    pulse_start(sc);
    feed(X0, X1, X2, 8'hFF, -1);
    wait_res(base + 2, 60);
    repeat (3) tick();
    check_pair("after_rst", base, db, R0, R1);

    // start pulses during LOAD and OUT are ignored
    out_ready = 1'b0;
    base = res_d.size(); db = done_cnt;
    pulse_start(sc);
    feed(X0, X1, X2, 8'hFF, 1);
    wait_valid(40);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    check("ign_still_out", 64'(out_valid), 64'd1);
    check("ign_out_data", out_data, R0);
    out_ready = 1'b1;
    wait_res(base + 2, 60);
    repeat (3) tick();
    check_pair("ign", base, db, R0, R1);
    check("ign_idle", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
